// File: rtl/rom_reader_pkg.sv
// Shared constants for the ROM stream reader.
//   IDLE/RUN/DRAIN : sequencer state encoding
//   FIFO_DEPTH     : number of words the output buffer can hold
package rom_reader_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/rom_rd_fifo.sv
// Two-entry register FIFO that buffers ROM words for the output stream.
// Ports:
//   clk, rst        : clock, async active-high reset
//   push, push_data : write strobe and word
//   pop, pop_data   : read strobe and head word (valid while !empty)
//   occ             : number of stored words, 0..2
//   full, empty     : occupancy flags
module rom_rd_fifo
   import rom_reader_pkg::*;
#(
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic [1:0]        occ,
   output logic              full,
   output logic              empty
);

   logic [DATA_W-1:0] mem [2];
   logic              wr_ptr;
   logic              rd_ptr;
   logic [1:0]        occ_r;
   logic              do_push;
   logic              do_pop;

   assign full     = (occ_r == 2'(FIFO_DEPTH));
   assign empty    = (occ_r == 2'd0);
   assign occ      = occ_r;
   assign pop_data = mem[rd_ptr];

   // A push into a full FIFO is only accepted when the head leaves on the same edge.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ_r  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop)
            rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   occ_r <= occ_r + 2'd1;
            2'b01:   occ_r <= occ_r - 2'd1;
            default: occ_r <= occ_r;
         endcase
      end
   end

endmodule

// File: rtl/rom_stream_reader.sv
// Read-side sequencer for a 1-cycle-latency synchronous ROM. Walks len words
// from base_addr (wrapping modulo ROM depth) and presents them as a
// valid/ready stream with full backpressure.
// Ports:
//   clk, rst             : clock, async active-high reset
//   start, base_addr, len: command (sampled only in IDLE)
//   rom_addr, rom_data   : ROM address out, registered ROM data in
//   out_data, out_valid, out_ready : output stream
//   busy                 : command in progress (RUN or DRAIN)
//   done                 : one-cycle pulse when a command completes
//
// state | meaning
// IDLE  | waiting for start; len=0 commands complete here
// RUN   | issuing ROM reads while remaining!=0 and credit allows
// DRAIN | all reads issued; waiting for the last word to be handed off
module rom_stream_reader
   import rom_reader_pkg::*;
#(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   logic [1:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W:0]   remaining;
   logic              pend;
   logic              done_r;

   logic [1:0]        occ;
   logic              full;
   logic              empty;
   logic              pop;
   logic [2:0]        in_flight;
   logic              credit_ok;
   logic              issue;
   logic              drain_done;

   assign rom_addr  = addr;
   assign out_valid = ~empty;
   assign busy      = (state != IDLE);
   assign done      = done_r;
   assign pop       = out_valid & out_ready;

   // Words buffered plus the read in flight must stay below the FIFO depth
   // after this edge's pop. The full case reduces to "pop with nothing in flight".
   assign in_flight = {1'b0, occ} + {2'b00, pend};
   assign credit_ok = full ? (pop & ~pend)
                           : (in_flight < (3'd2 + {2'b00, pop}));

   assign issue = (state == RUN) && (remaining != '0) && credit_ok;

   // Leave DRAIN on the edge that hands off the final word, so done lands in
   // the cycle right after the last handshake.
   assign drain_done = (state == DRAIN) && !pend && (occ == {1'b0, pop});

   rom_rd_fifo #(
      .DATA_W(DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (pend),
      .push_data(rom_data),
      .pop      (pop),
      .pop_data (out_data),
      .occ      (occ),
      .full     (full),
      .empty    (empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         pend      <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         done_r <= 1'b0;
         pend   <= issue;
         if (issue) begin
            addr      <= addr + 1'b1;
            remaining <= remaining - 1'b1;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  if (len != '0) begin
                     state     <= RUN;
                     addr      <= base_addr;
                     remaining <= len;
                  end else begin
                     done_r <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (remaining == '0)
                  state <= DRAIN;
            end
            DRAIN: begin
               if (drain_done) begin
                  state  <= IDLE;
                  done_r <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rom_stream_reader.sv
module tb_rom_stream_reader;

   logic       clk;
   logic       rst;
   logic       start;
   logic [2:0] base_addr;
   logic [3:0] len;
   logic [2:0] rom_addr;
   logic [1:0] rom_data;
   logic [1:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;
   int got_q[$];
   int done_cnt = 0;
   int done_cyc = 0;
   int last_hs_cyc = 0;
   int cyc = 0;
   bit stalled = 0;
   int held = 0;
   logic [1:0] rom_mem [8];
   int pat [7];

   rom_stream_reader #(.ADDR_W(3), .DATA_W(2)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .base_addr(base_addr),
      .len      (len),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy     (busy),
      .done     (done)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // 1-cycle synchronous ROM
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Stream monitor: collects handshaked words, done pulses and stall rules.
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         stalled = 0;
      end else begin
         if (stalled) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_data", int'(out_data), held);
         end
         chk("fifo_occ_le2", int'(dut.u_fifo.occ <= 2'd2), 1);
         chk("fifo_overflow", int'(dut.u_fifo.push & dut.u_fifo.full & ~dut.u_fifo.pop), 0);
         if (out_valid && out_ready) begin
            got_q.push_back(int'(out_data));
            last_hs_cyc = cyc;
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stalled = out_valid && !out_ready;
         held    = int'(out_data);
      end
   end

   function automatic logic next_ready(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return pat[c % 7][0];
      return 1'($urandom_range(0, 1));
   endfunction

   // Issues one command (caller is just after a rising edge, reader idle) and
   // checks the resulting stream against the ROM contents.
   task automatic run_cmd(input int b, input int n, input int mode, input bit inject, input bit lat_chk);
      int exp_q[$];
      int d0;
      got_q.delete();
      d0 = done_cnt;
      for (int j = 0; j < n; j++) exp_q.push_back(int'(rom_mem[(b + j) % 8]));
      start     = 1;
      base_addr = 3'(b);
      len       = 4'(n);
      out_ready = 1;
      @(posedge clk); #1;
      start = 0;
      for (int c = 0; c < 200 && done_cnt == d0; c++) begin
         if (c == 1) begin
            chk("busy_in_cmd", int'(busy), int'(n != 0));
            if (lat_chk) chk("latency_k1_invalid", int'(out_valid), 0);
         end
         if (c == 2 && lat_chk) chk("latency_k2_valid", int'(out_valid), 1);
         out_ready = next_ready(mode, c);
         if (inject && c == 2) begin
            start     = 1;
            base_addr = 3'd3;
            len       = 4'd2;
         end else begin
            start = 0;
         end
         @(posedge clk); #1;
      end
      start     = 0;
      out_ready = 1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      chk("done_count", done_cnt - d0, 1);
      chk("word_count", got_q.size(), n);
      for (int j = 0; j < n && j < got_q.size(); j++) chk("word_value", got_q[j], exp_q[j]);
      if (n > 0) chk("done_after_last", done_cyc, last_hs_cyc + 1);
      chk("busy_after_done", int'(busy), 0);
   endtask

   initial begin
      int d0;
      for (int i = 0; i < 8; i++) rom_mem[i] = 2'(i % 4);
      pat = '{1, 0, 0, 1, 0, 1, 1};
      rst = 1; start = 0; base_addr = 0; len = 0; out_ready = 0;
      #1;
      chk("reset_outputs", int'({out_valid, busy, done, out_data, rom_addr}), 0);
      repeat (2) @(posedge clk);
      #1 rst = 0;

      // idle, no start
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_outputs", int'({out_valid, busy, done, out_data, rom_addr}), 0);
      end
      @(posedge clk); #1;

      // reset mid-command
      got_q.delete();
      out_ready = 1; start = 1; base_addr = 0; len = 8;
      @(posedge clk); #1;
      start = 0;
      for (int c = 0; c < 50 && got_q.size() < 3; c++) begin
         @(posedge clk); #1;
      end
      chk("rst_test_3_words", int'(got_q.size() >= 3), 1);
      d0 = done_cnt;
      #2 rst = 1;
      #1;
      chk("async_rst_outputs", int'({out_valid, busy, done, out_data, rom_addr}), 0);
      @(posedge clk); #1;
      rst = 0;
      repeat (6) begin
         @(posedge clk); #1;
      end
      chk("no_done_after_rst", done_cnt - d0, 0);
      chk("idle_after_rst", int'({out_valid, busy}), 0);

      run_cmd(0, 4, 0, 0, 1);   // basic read with latency check
      run_cmd(6, 4, 0, 0, 0);   // wrap-around
      run_cmd(0, 8, 1, 0, 0);   // patterned backpressure
      run_cmd(0, 0, 0, 0, 0);   // len=0
      run_cmd(5, 8, 0, 0, 0);   // full-depth from base 5
      run_cmd(0, 8, 0, 1, 0);   // start while busy ignored
      run_cmd(1, 6, 2, 1, 0);
      for (int t = 0; t < 12; t++)
         run_cmd(int'($urandom_range(0, 7)), int'($urandom_range(0, 8)), 2, 1'($urandom_range(0, 1)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
